// File: rtl/usbkbd_pkg.sv
// Shared constants, FSM states, event payload and report-slot helpers for the keyboard event decoder.
package usbkbd_pkg;

   localparam logic [7:0]  USB_USAGE_ROLLOVER = 8'h01;
   localparam logic [7:0]  USB_USAGE_MOD_BASE = 8'hE0;
   localparam int unsigned NUM_SLOTS          = 6;
   localparam int unsigned NUM_MODS           = 8;
   localparam int unsigned REPORT_W           = 64;
   localparam int unsigned EV_W               = 9;
   localparam int unsigned EV_MAKE            = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_MODS   = 3'd2,
      ST_BRK    = 3'd3,
      ST_MAK    = 3'd4,
      ST_COMMIT = 3'd5
   } state_e;

   // Event word: bit 8 is make(1)/break(0), bits 7:0 the HID usage
   typedef struct packed {
      logic       make;
      logic [7:0] usage;
   } event_t;

   // Keycode in slot k (0..5)
   function automatic logic [7:0] slot_code(input logic [63:0] rep, input int unsigned k);
      return rep[8*k+16 +: 8];
   endfunction

   // True when code appears in any of the six slots
   function automatic logic has_code(input logic [63:0] rep, input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         if (slot_code(rep, k) == code) hit = 1'b1;
      end
      return hit;
   endfunction

   // True when code appears in a slot strictly below idx
   function automatic logic dup_before(input logic [63:0] rep, input logic [2:0] idx,
                                       input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         if ((3'(k) < idx) && (slot_code(rep, k) == code)) hit = 1'b1;
      end
      return hit;
   endfunction

   // True when any slot carries the ErrorRollOver usage
   function automatic logic is_rollover(input logic [63:0] rep);
      return has_code(rep, USB_USAGE_ROLLOVER);
   endfunction

endpackage

// File: rtl/usbkbd_event_fifo.sv
// First-word fall-through event FIFO; a push while full is accepted only alongside a pop.
module usbkbd_event_fifo
   import usbkbd_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             wr_en_c, rd_en_c;

   assign full     = (level_q == LW'(DEPTH));
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Pointer and occupancy update
   always_comb begin
      wr_en_c  = push && (!full || pop);
      rd_en_c  = pop && !empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (wr_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en_c) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en_c && !rd_en_c) level_d = level_q + LW'(1);
      else if (!wr_en_c && rd_en_c) level_d = level_q - LW'(1);
   end

   // Control registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (wr_en_c) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/usbkbd_event_decoder.sv
// Latches each HID boot report, acknowledges it, and emits make/break events for the diff against the previous report.
module usbkbd_event_decoder
   import usbkbd_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned FIFO_AW    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [63:0]       report,
   input  logic              interrupt,
   output logic              intack,
   output logic              ev_valid,
   output logic [8:0]        ev_data,
   input  logic              ev_ready,
   output logic [FIFO_AW:0]  ev_level,
   output logic              busy
);

   state_e        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [63:0]   cur_q, cur_d;
   logic [63:0]   prev_q, prev_d;
   logic          intack_q, intack_d;
   logic          busy_q, busy_d;

   logic          push_c;
   event_t        push_data_c;
   logic [7:0]    code_c;
   logic          pop_c;
   logic          fifo_full, fifo_empty;
   logic          room_c;
   logic          unused_reserved_c;

   // Reserved byte is carried in the latched reports but never decoded
   assign unused_reserved_c = ^{cur_q[15:8], prev_q[15:8]};

   assign pop_c    = ev_ready && !fifo_empty;
   assign room_c   = !fifo_full || pop_c;
   assign ev_valid = !fifo_empty;
   assign intack   = intack_q;
   assign busy     = busy_q;

   // Next-state, scan index and event generation
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cur_d       = cur_q;
      prev_d      = prev_q;
      intack_d    = 1'b0;
      push_c      = 1'b0;
      push_data_c = '0;
      code_c      = 8'h00;

      case (state_q)
         ST_IDLE: begin
            if (interrupt) begin
               cur_d    = report;
               intack_d = 1'b1;
               state_d  = ST_CHECK;
            end
         end

         ST_CHECK: begin
            idx_d   = '0;
            state_d = is_rollover(cur_q) ? ST_IDLE : ST_MODS;
         end

         ST_MODS: begin
            if (cur_q[idx_q] != prev_q[idx_q]) begin
               push_c      = 1'b1;
               push_data_c = '{make: cur_q[idx_q], usage: USB_USAGE_MOD_BASE + 8'(idx_q)};
            end
            if (!push_c || room_c) begin
               if (idx_q == 3'(NUM_MODS - 1)) begin
                  idx_d   = '0;
                  state_d = ST_BRK;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         ST_BRK: begin
            code_c = slot_code(prev_q, 32'(idx_q));
            if ((code_c != 8'h00) && !dup_before(prev_q, idx_q, code_c) &&
                !has_code(cur_q, code_c)) begin
               push_c      = 1'b1;
               push_data_c = '{make: 1'b0, usage: code_c};
            end
            if (!push_c || room_c) begin
               if (idx_q == 3'(NUM_SLOTS - 1)) begin
                  idx_d   = '0;
                  state_d = ST_MAK;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         ST_MAK: begin
            code_c = slot_code(cur_q, 32'(idx_q));
            if ((code_c != 8'h00) && !dup_before(cur_q, idx_q, code_c) &&
                !has_code(prev_q, code_c)) begin
               push_c      = 1'b1;
               push_data_c = '{make: 1'b1, usage: code_c};
            end
            if (!push_c || room_c) begin
               if (idx_q == 3'(NUM_SLOTS - 1)) begin
                  idx_d   = '0;
                  state_d = ST_COMMIT;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end

         ST_COMMIT: begin
            prev_d  = cur_q;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         cur_q    <= '0;
         prev_q   <= '0;
         intack_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cur_q    <= cur_d;
         prev_q   <= prev_d;
         intack_q <= intack_d;
         busy_q   <= busy_d;
      end
   end

   usbkbd_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW),
      .WIDTH (EV_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_c),
      .push_data (push_data_c),
      .pop       (ev_ready),
      .pop_data  (ev_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (ev_level)
   );

endmodule

// File: tb/tb_usbkbd_event_decoder.sv
// Scoreboard bench: a keyboard-core model issues reports, a report-diff model queues expected events, a monitor checks pops.
module tb_usbkbd_event_decoder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;

   logic          clk;
   logic          rst;
   logic [63:0]   report;
   logic          interrupt;
   logic          intack;
   logic          ev_valid;
   logic [8:0]    ev_data;
   logic          ev_ready;
   logic [AW:0]   ev_level;
   logic          busy;

   int unsigned   n_checks;
   int unsigned   n_pass;
   int unsigned   intack_seen;
   int unsigned   intack_exp;
   int unsigned   ready_mode;
   logic [8:0]    exp_q[$];
   logic [63:0]   model_prev;

   usbkbd_event_decoder #(
      .FIFO_DEPTH (DEPTH),
      .FIFO_AW    (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .report    (report),
      .interrupt (interrupt),
      .intack    (intack),
      .ev_valid  (ev_valid),
      .ev_data   (ev_data),
      .ev_ready  (ev_ready),
      .ev_level  (ev_level),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic in_list(input logic [7:0] lst[$], input logic [7:0] code);
      foreach (lst[i]) if (lst[i] == code) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic rollover_rep(input logic [63:0] r);
      for (int k = 0; k < 6; k++) if (r[8*k+16 +: 8] == 8'h01) return 1'b1;
      return 1'b0;
   endfunction

   // Expected events for a report transition, straight from the make/break rules
   function automatic void model_events(input logic [63:0] p, input logic [63:0] c);
      logic [7:0] ps[$];
      logic [7:0] cs[$];
      logic [7:0] seen[$];
      for (int k = 0; k < 6; k++) begin
         ps.push_back(p[8*k+16 +: 8]);
         cs.push_back(c[8*k+16 +: 8]);
      end
      for (int b = 0; b < 8; b++)
         if (p[b] != c[b]) exp_q.push_back({c[b], 8'hE0 + 8'(b)});
      seen = {};
      foreach (ps[k]) begin
         if (ps[k] != 8'h00 && !in_list(seen, ps[k]) && !in_list(cs, ps[k]))
            exp_q.push_back({1'b0, ps[k]});
         seen.push_back(ps[k]);
      end
      seen = {};
      foreach (cs[k]) begin
         if (cs[k] != 8'h00 && !in_list(seen, cs[k]) && !in_list(ps, cs[k]))
            exp_q.push_back({1'b1, cs[k]});
         seen.push_back(cs[k]);
      end
   endfunction

   // Keyboard core: present a report once the previous one is acknowledged
   task automatic send_report(input logic [63:0] r);
      int unsigned t;
      t = 0;
      @(negedge clk);
      while (interrupt && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (interrupt) check("core_handshake_timeout", 64'(interrupt), 64'd0);
      report    = r;
      interrupt = 1'b1;
      intack_exp++;
      if (!rollover_rep(r)) begin
         model_events(model_prev, r);
         model_prev = r;
      end
   endtask

   task automatic wait_scan_done();
      int unsigned t;
      t = 0;
      @(negedge clk);
      while ((interrupt || busy) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (interrupt || busy) check("scan_timeout", 64'(busy), 64'd0);
   endtask

   task automatic wait_drain();
      int unsigned t;
      t = 0;
      @(negedge clk);
      while ((interrupt || busy || exp_q.size() != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("drain_remaining", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_intack"},   64'(intack),   64'd0);
      check({tag, "_ev_valid"}, 64'(ev_valid), 64'd0);
      check({tag, "_ev_level"}, 64'(ev_level), 64'd0);
      check({tag, "_busy"},     64'(busy),     64'd0);
   endtask

   // Keyboard core drops interrupt when it sees intack
   always @(negedge clk) begin
      if (intack) begin
         intack_seen++;
         interrupt = 1'b0;
      end
   end

   // Consumer ready, changed just after the active edge
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       ev_ready = 1'b0;
         1:       ev_ready = 1'b1;
         default: ev_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: every pop is compared against the scoreboard head
   always @(negedge clk) begin
      if (!rst && ev_valid && ev_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got %0h expected none", ev_data);
         end else begin
            check("event", 64'(ev_data), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      logic [63:0] r;
      logic [7:0]  k8;
      int unsigned lat;
      n_checks    = 0;
      n_pass      = 0;
      intack_seen = 0;
      intack_exp  = 0;
      ready_mode  = 0;
      model_prev  = '0;
      rst         = 1'b1;
      report      = '0;
      interrupt   = 1'b0;
      ev_ready    = 1'b0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Single key make
      send_report(64'h0000_0000_0004_0000);
      wait_scan_done();
      check("t1_level", 64'(ev_level), 64'd1);
      check("t1_head", 64'(ev_data), 64'h104);
      check("t1_intack_count", 64'(intack_seen), 64'd1);
      ready_mode = 1;
      wait_drain();

      // Key release, then two modifier makes with first-event latency
      send_report(64'h0);
      wait_drain();
      ready_mode = 0;
      repeat (2) @(negedge clk);
      send_report(64'h0000_0000_0000_0022);
      lat = 0;
      while (!ev_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      check("t2_latency_le4", 64'(lat <= 4), 64'd1);
      wait_scan_done();
      check("t2_level", 64'(ev_level), 64'd2);
      check("t2_head", 64'(ev_data), 64'h1E1);
      ready_mode = 1;
      wait_drain();

      // Overlapping key sets: 05 held, 04 breaks, 06 makes
      send_report(64'h0000_0000_0504_0000);
      wait_drain();
      ready_mode = 0;
      send_report(64'h0000_0000_0605_0000);
      wait_scan_done();
      check("t3_level", 64'(ev_level), 64'd2);
      check("t3_head", 64'(ev_data), 64'h004);
      ready_mode = 1;
      wait_drain();

      // ErrorRollOver report is discarded; next diff uses pre-rollover state
      ready_mode = 0;
      send_report(64'h0101_0101_0101_0000);
      wait_scan_done();
      check("t4_rollover_level", 64'(ev_level), 64'd0);
      check("t4_intack_count", 64'(intack_seen), 64'(intack_exp));
      send_report(64'h0000_0000_0006_0000);
      wait_scan_done();
      check("t4_level", 64'(ev_level), 64'd1);
      check("t4_head", 64'(ev_data), 64'h005);
      ready_mode = 1;
      wait_drain();

      // Back-pressure: 14 events into a 4-deep FIFO with consumer stalled
      send_report(64'h0);
      wait_drain();
      ready_mode = 0;
      send_report(64'h0A09_0807_0605_00FF);
      repeat (40) @(negedge clk);
      check("t5_level_full", 64'(ev_level), 64'(DEPTH));
      check("t5_busy", 64'(busy), 64'd1);
      check("t5_pending", 64'(exp_q.size()), 64'd14);
      ready_mode = 1;
      wait_drain();

      // Reset mid-MAK with the report still pending in the core
      r = 64'h0000_0016_1514_0000;
      send_report(r);
      lat = 0;
      while (intack_seen != intack_exp && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      repeat (17) @(posedge clk);
      #1;
      rst        = 1'b1;
      interrupt  = 1'b1;
      exp_q      = {};
      model_prev = '0;
      intack_exp++;
      model_events(model_prev, r);
      model_prev = r;
      repeat (2) @(negedge clk);
      check_reset_outputs("t6_reset");
      rst = 1'b0;
      wait_drain();

      // Randomized reports with random consumer back-pressure
      ready_mode = 2;
      for (int n = 0; n < 30; n++) begin
         r = '0;
         r[7:0] = 8'($urandom_range(0, 255));
         r[15:8] = 8'($urandom_range(0, 255));
         for (int k = 0; k < 6; k++) begin
            k8 = 8'($urandom_range(4, 11));
            if ($urandom_range(0, 2) == 0) k8 = 8'h00;
            r[8*k+16 +: 8] = k8;
         end
         if ($urandom_range(0, 9) == 0) r[8*3+16 +: 8] = 8'h01;
         send_report(r);
      end
      wait_drain();
      ready_mode = 1;
      repeat (5) @(negedge clk);
      check("final_level", 64'(ev_level), 64'd0);
      check("final_intack_count", 64'(intack_seen), 64'(intack_exp));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
